// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings and shadow-pipeline record types for the hazard/forwarding controller.
package hazard_forward_unit_pkg;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       regwrite;
    logic       memread;
  } ex_stage_t;

  typedef struct packed {
    logic [4:0] dst;
    logic       regwrite;
  } wr_stage_t;

  // $0 is hardwired, so a write to it never produces a usable value.
  function automatic logic dst_hits(input logic [4:0] dst, input logic we, input logic [4:0] src);
    return we && (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-facing signals of the hazard/forwarding controller.
interface hazard_forward_unit_if #(parameter int CNT_W = 16);

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_dst;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_uses_rt;
  logic             branch_taken;
  logic [1:0]       forwardA;
  logic [1:0]       forwardB;
  logic             pc_hold;
  logic             ifid_hold;
  logic             idex_bubble;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_dst, id_regwrite, id_memread, id_uses_rt, branch_taken,
    input  forwardA, forwardB, pc_hold, ifid_hold, idex_bubble, flush, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_dst, id_regwrite, id_memread, id_uses_rt, branch_taken,
    output forwardA, forwardB, pc_hold, ifid_hold, idex_bubble, flush, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// Operand source select for one EX operand; the EX/MEM result wins over the WB result.
module hazard_forward_unit_fwd_select
  import hazard_forward_unit_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic [4:0] i_mem_dst,
  input  logic       i_mem_we,
  input  logic [4:0] i_wb_dst,
  input  logic       i_wb_we,
  output logic [1:0] o_sel
);

  always_comb begin
    o_sel = FWD_REG;
    if (dst_hits(i_mem_dst, i_mem_we, i_src))
      o_sel = FWD_MEM;
    else if (dst_hits(i_wb_dst, i_wb_we, i_src))
      o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller: shadow pipeline of in-flight destinations, load-use stall,
// taken-branch flush and saturating event counters.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  hazard_forward_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ex_stage_t        r_ex;
  wr_stage_t        r_mem;
  wr_stage_t        r_wb;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_flush;
  logic w_load_use;
  logic w_stall;

  // Gated by reset so no flush is seen while the block is held in reset.
  assign w_flush    = bus.branch_taken & reset;
  assign w_load_use = r_ex.memread && (r_ex.dst != REG_ZERO) &&
                      ((r_ex.dst == bus.id_rs) || (bus.id_uses_rt && (r_ex.dst == bus.id_rt)));
  assign w_stall    = w_load_use & ~w_flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_wb <= r_mem;
      if (w_flush) begin
        r_ex  <= '0;
        r_mem <= '0;
      end else begin
        r_mem <= '{dst: r_ex.dst, regwrite: r_ex.regwrite};
        if (w_stall)
          r_ex <= '0;
        else
          r_ex <= '{rs: bus.id_rs, rt: bus.id_rt, dst: bus.id_dst,
                    regwrite: bus.id_regwrite, memread: bus.id_memread};
      end
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  hazard_forward_unit_fwd_select u_fwd_a (
    .i_src     (r_ex.rs),
    .i_mem_dst (r_mem.dst),
    .i_mem_we  (r_mem.regwrite),
    .i_wb_dst  (r_wb.dst),
    .i_wb_we   (r_wb.regwrite),
    .o_sel     (bus.forwardA)
  );

  hazard_forward_unit_fwd_select u_fwd_b (
    .i_src     (r_ex.rt),
    .i_mem_dst (r_mem.dst),
    .i_mem_we  (r_mem.regwrite),
    .i_wb_dst  (r_wb.dst),
    .i_wb_we   (r_wb.regwrite),
    .o_sel     (bus.forwardB)
  );

  assign bus.pc_hold     = w_stall;
  assign bus.ifid_hold   = w_stall;
  assign bus.idex_bubble = w_stall;
  assign bus.flush       = w_flush;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit; narrow counters keep the saturation run short.
module tb_hazard_forward_unit;

  localparam int TB_CNT_W = 8;
  localparam int N_SAT    = (1 << TB_CNT_W) + 3;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  hazard_forward_unit_if #(.CNT_W(TB_CNT_W)) bus ();

  hazard_forward_unit #(.CNT_W(TB_CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                        input logic rw, input logic mr, input logic ur);
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_dst      = dst;
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.id_uses_rt  = ur;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.branch_taken = 1'b0;
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    reset = 1'b0;
    bus.branch_taken = 1'b1;
    #1;
    n_cmp++;
    if (bus.flush !== 1'b0) begin n_err++; $display("FAIL reset_flush got %b want 0", bus.flush); end
    n_cmp++;
    if ({bus.forwardA, bus.forwardB} !== 4'b0000) begin
      n_err++; $display("FAIL reset_fwd got %b%b want 0000", bus.forwardA, bus.forwardB);
    end
    n_cmp++;
    if ({bus.pc_hold, bus.ifid_hold, bus.idex_bubble} !== 3'b000) begin
      n_err++; $display("FAIL reset_hold got %b%b%b want 000", bus.pc_hold, bus.ifid_hold, bus.idex_bubble);
    end
    n_cmp++;
    if ({bus.stall_cnt, bus.flush_cnt} !== '0) begin
      n_err++; $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt);
    end
    bus.branch_taken = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // add $3,$1,$2 ; sub $4,$3,$5
  task automatic test_fwd_ex_mem();
    apply_reset();
    set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1); step();
    set_id(5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b1); step();
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
    n_cmp++;
    if (bus.forwardA !== 2'b10) begin n_err++; $display("FAIL exmem_fwdA got %b want 10", bus.forwardA); end
    n_cmp++;
    if (bus.forwardB !== 2'b00) begin n_err++; $display("FAIL exmem_fwdB got %b want 00", bus.forwardB); end
  endtask

  // add $3 ; nop ; or $6,$5,$3, then the EX/MEM-over-WB priority and a non-writing match
  task automatic test_fwd_wb();
    apply_reset();
    set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1); step();
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); step();
    set_id(5'd5, 5'd3, 5'd6, 1'b1, 1'b0, 1'b1); step();
    n_cmp++;
    if (bus.forwardB !== 2'b01) begin n_err++; $display("FAIL wb_fwdB got %b want 01", bus.forwardB); end
    n_cmp++;
    if (bus.forwardA !== 2'b00) begin n_err++; $display("FAIL wb_fwdA got %b want 00", bus.forwardA); end
    set_id(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1); step();
    set_id(5'd7, 5'd8, 5'd3, 1'b1, 1'b0, 1'b1); step();
    set_id(5'd3, 5'd3, 5'd9, 1'b1, 1'b0, 1'b1); step();
    n_cmp++;
    if ({bus.forwardA, bus.forwardB} !== 4'b1010) begin
      n_err++; $display("FAIL prio_fwd got %b%b want 1010", bus.forwardA, bus.forwardB);
    end
    set_id(5'd3, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1); step();
    set_id(5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1); step();
    n_cmp++;
    if (bus.forwardA !== 2'b00) begin n_err++; $display("FAIL nowrite_fwdA got %b want 00", bus.forwardA); end
  endtask

  // lw $2,0($1) ; add $4,$2,$2 -- the add enters EX when the load has reached WB
  task automatic test_load_use();
    apply_reset();
    set_id(5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0); step();
    set_id(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1); #1;
    n_cmp++;
    if ({bus.pc_hold, bus.ifid_hold, bus.idex_bubble, bus.flush} !== 4'b1110) begin
      n_err++; $display("FAIL lu_stall got %b%b%b%b want 1110", bus.pc_hold, bus.ifid_hold, bus.idex_bubble, bus.flush);
    end
    step();
    n_cmp++;
    if ({bus.pc_hold, bus.forwardA} !== 3'b000) begin
      n_err++; $display("FAIL lu_after got hold=%b fwdA=%b want 0/00", bus.pc_hold, bus.forwardA);
    end
    step();
    n_cmp++;
    if ({bus.forwardA, bus.forwardB} !== 4'b0101) begin
      n_err++; $display("FAIL lu_fwd got %b%b want 0101", bus.forwardA, bus.forwardB);
    end
    n_cmp++;
    if (bus.stall_cnt !== 8'd1) begin n_err++; $display("FAIL lu_cnt got %0d want 1", bus.stall_cnt); end
    set_id(5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0); step();
    set_id(5'd5, 5'd2, 5'd6, 1'b1, 1'b0, 1'b0); #1;
    n_cmp++;
    if (bus.pc_hold !== 1'b0) begin n_err++; $display("FAIL lu_no_rt got %b want 0", bus.pc_hold); end
  endtask

  // addi $0,$1,5 ; add $7,$0,$0 ; lw $0 ; use of $0
  task automatic test_reg_zero();
    apply_reset();
    set_id(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); step();
    set_id(5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1); step();
    n_cmp++;
    if ({bus.forwardA, bus.forwardB} !== 4'b0000) begin
      n_err++; $display("FAIL zero_fwd got %b%b want 0000", bus.forwardA, bus.forwardB);
    end
    set_id(5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0); step();
    set_id(5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1); #1;
    n_cmp++;
    if (bus.pc_hold !== 1'b0) begin n_err++; $display("FAIL zero_stall got %b want 0", bus.pc_hold); end
    step();
    n_cmp++;
    if (bus.stall_cnt !== 8'd0) begin n_err++; $display("FAIL zero_cnt got %0d want 0", bus.stall_cnt); end
  endtask

  // load-use hazard coinciding with a taken branch
  task automatic test_stall_flush();
    apply_reset();
    set_id(5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0); step();
    set_id(5'd2, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1);
    bus.branch_taken = 1'b1; #1;
    n_cmp++;
    if ({bus.flush, bus.pc_hold, bus.ifid_hold, bus.idex_bubble} !== 4'b1000) begin
      n_err++; $display("FAIL sf_ctrl got %b%b%b%b want 1000", bus.flush, bus.pc_hold, bus.ifid_hold, bus.idex_bubble);
    end
    step();
    bus.branch_taken = 1'b0;
    set_id(5'd2, 5'd2, 5'd8, 1'b1, 1'b0, 1'b1); #1;
    n_cmp++;
    if ({bus.forwardA, bus.forwardB} !== 4'b0000) begin
      n_err++; $display("FAIL sf_fwd got %b%b want 0000", bus.forwardA, bus.forwardB);
    end
    n_cmp++;
    if ({bus.flush_cnt, bus.stall_cnt} !== {8'd1, 8'd0}) begin
      n_err++; $display("FAIL sf_cnt got flush=%0d stall=%0d want 1/0", bus.flush_cnt, bus.stall_cnt);
    end
    step();
    n_cmp++;
    if ({bus.forwardA, bus.forwardB} !== 4'b0000) begin
      n_err++; $display("FAIL sf_squash got %b%b want 0000", bus.forwardA, bus.forwardB);
    end
  endtask

  // counters saturate, then an async reset lands in the middle of a stall
  task automatic test_saturation();
    apply_reset();
    set_id(5'd2, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0);
    bus.branch_taken = 1'b1;
    repeat (N_SAT) step();
    n_cmp++;
    if (bus.flush_cnt !== 8'hFF) begin n_err++; $display("FAIL sat_flush got %0d want 255", bus.flush_cnt); end
    bus.branch_taken = 1'b0;
    repeat (2 * N_SAT) step();
    n_cmp++;
    if (bus.stall_cnt !== 8'hFF) begin n_err++; $display("FAIL sat_stall got %0d want 255", bus.stall_cnt); end
    step();
    n_cmp++;
    if (bus.pc_hold !== 1'b1) begin n_err++; $display("FAIL sat_midstall got %b want 1", bus.pc_hold); end
    #2;
    reset = 1'b0;
    bus.branch_taken = 1'b1;
    #1;
    n_cmp++;
    if ({bus.forwardA, bus.forwardB, bus.pc_hold, bus.ifid_hold, bus.idex_bubble, bus.flush} !== 8'h00) begin
      n_err++; $display("FAIL async_out got %b%b%b%b%b%b want 0", bus.forwardA, bus.forwardB,
                        bus.pc_hold, bus.ifid_hold, bus.idex_bubble, bus.flush);
    end
    n_cmp++;
    if ({bus.stall_cnt, bus.flush_cnt} !== 16'h0000) begin
      n_err++; $display("FAIL async_cnt got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt);
    end
    bus.branch_taken = 1'b0;
    step();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus.pc_hold !== 1'b0) begin n_err++; $display("FAIL post_reset_hold got %b want 0", bus.pc_hold); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.branch_taken = 1'b0;
    set_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_fwd_ex_mem();
    test_fwd_wb();
    test_load_use();
    test_reg_zero();
    test_stall_flush();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
